rtc_bus_sequencer: RTL and testbench

- Timing/sequencing stage directly upstream of the RTC bus mux.
- Turns a single-cycle transaction request (write or read) into a two-phase multiplexed address/data transaction on the RTC bus.
- Generates the RTC strobes (cs_n, ad_n, wr_n, rd_n) and the mux control flags: phase select, direction, drive enable, bus release.
- Emits a capture strobe for read data and a done pulse for the upstream protocol FSM.

---
 rtl/rtc_bus_pkg.sv | 68 ++++++
 rtl/rtc_phase_timer.sv | 37 +++
 rtl/rtc_bus_sequencer.sv | 168 ++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared types, default timing and encodings for the RTC bus sequencer.
// The REC state is only reachable when RTC_RECOVERY_EN is defined.
package rtc_bus_pkg;

    localparam int unsigned DEF_T_SETUP = 2;
    localparam int unsigned DEF_T_PULSE = 4;
    localparam int unsigned DEF_T_HOLD  = 2;
    localparam int unsigned DEF_T_REC   = 4;
    localparam int unsigned DEF_CNT_W   = 4;

    localparam logic PHASE_ADDR = 1'b0;
    localparam logic PHASE_DATA = 1'b1;
    localparam logic DIR_READ   = 1'b0;
    localparam logic DIR_WRITE  = 1'b1;

    typedef enum logic [3:0] {
        StIdle,
        StASetup,
        StAPulse,
        StAHold,
        StDSetup,
        StDPulse,
        StDHold,
        StDone,
        StRec
    } state_e;

    typedef struct packed {
        logic busy;
        logic done;
        logic rd_capture;
        logic cs_n;
        logic ad_n;
        logic wr_n;
        logic rd_n;
        logic flag_dato;
        logic direccion_dato;
        logic controlador_dato;
        logic bus_release;
    } bus_out_t;

    localparam bus_out_t BUS_OUT_IDLE = '{
        busy:             1'b0,
        done:             1'b0,
        rd_capture:       1'b0,
        cs_n:             1'b1,
        ad_n:             1'b1,
        wr_n:             1'b1,
        rd_n:             1'b1,
        flag_dato:        1'b0,
        direccion_dato:   PHASE_ADDR,
        controlador_dato: DIR_READ,
        bus_release:      1'b0
    };

    function automatic logic is_addr_state(input state_e s);
        return s inside {StASetup, StAPulse, StAHold};
    endfunction

    function automatic logic is_data_state(input state_e s);
        return s inside {StDSetup, StDPulse, StDHold};
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter shared by every timed state of the sequencer.
// Holds at zero once expired until the next load.
module rtc_phase_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value   = cnt_q;
    assign expired = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Two-phase multiplexed address/data sequencer for the RTC bus; outputs are registered
// from the next state. Define RTC_RECOVERY_EN to add a T_REC-cycle recovery state after DONE.
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int unsigned T_SETUP = DEF_T_SETUP,
    parameter int unsigned T_PULSE = DEF_T_PULSE,
    parameter int unsigned T_HOLD  = DEF_T_HOLD,
`ifdef RTC_RECOVERY_EN
    parameter int unsigned T_REC   = DEF_T_REC,
`endif
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic rw,
    output logic busy,
    output logic done,
    output logic rd_capture,
    output logic cs_n,
    output logic ad_n,
    output logic wr_n,
    output logic rd_n,
    output logic flag_dato,
    output logic direccion_dato,
    output logic controlador_dato,
    output logic bus_release
);

`ifdef RTC_RECOVERY_EN
    localparam int unsigned T_MAX = max_u(max_u(max_u(T_SETUP, T_PULSE), T_HOLD), T_REC);
`else
    localparam int unsigned T_MAX = max_u(max_u(T_SETUP, T_PULSE), T_HOLD);
`endif

    if (T_SETUP < 1 || T_PULSE < 1 || T_HOLD < 1) begin : g_bad_timing
        $error("rtc_bus_sequencer: T_SETUP, T_PULSE and T_HOLD must be at least 1");
    end
`ifdef RTC_RECOVERY_EN
    if (T_REC < 1) begin : g_bad_rec
        $error("rtc_bus_sequencer: T_REC must be at least 1");
    end
`endif
    if (64'(T_MAX) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
        $error("rtc_bus_sequencer: CNT_W too narrow for the timing parameters");
    end

    state_e           state_q, state_d;
    logic             rw_q, rw_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_expired;
    logic             last_next;
    bus_out_t         out_q, out_d;

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StASetup;
                    rw_d    = rw;
                end
            end
            StASetup: if (tmr_expired) state_d = StAPulse;
            StAPulse: if (tmr_expired) state_d = StAHold;
            StAHold:  if (tmr_expired) state_d = StDSetup;
            StDSetup: if (tmr_expired) state_d = StDPulse;
            StDPulse: if (tmr_expired) state_d = StDHold;
            StDHold:  if (tmr_expired) state_d = StDone;
`ifdef RTC_RECOVERY_EN
            StDone:   state_d = StRec;
            StRec:    if (tmr_expired) state_d = StIdle;
`else
            StDone:   state_d = StIdle;
`endif
            default:  state_d = StIdle;
        endcase
    end

    // Every state change reloads the timer with the duration of the state being entered.
    assign tmr_load = (state_d != state_q);

    always_comb begin
        tmr_load_val = '0;
        case (state_d)
            StASetup, StDSetup: tmr_load_val = CNT_W'(T_SETUP - 1);
            StAPulse, StDPulse: tmr_load_val = CNT_W'(T_PULSE - 1);
            StAHold,  StDHold:  tmr_load_val = CNT_W'(T_HOLD - 1);
`ifdef RTC_RECOVERY_EN
            StRec:              tmr_load_val = CNT_W'(T_REC - 1);
`endif
            default:            tmr_load_val = '0;
        endcase
    end

    rtc_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .value    (tmr_value),
        .expired  (tmr_expired)
    );

    // True when the cycle about to start is the final cycle of its state.
    assign last_next = tmr_load ? (tmr_load_val == '0) : (tmr_value == CNT_W'(1));

    always_comb begin
        out_d      = BUS_OUT_IDLE;
        out_d.busy = (state_d != StIdle);
        if (is_addr_state(state_d)) begin
            out_d.cs_n             = 1'b0;
            out_d.ad_n             = PHASE_ADDR;
            out_d.flag_dato        = 1'b1;
            out_d.direccion_dato   = PHASE_ADDR;
            out_d.controlador_dato = DIR_WRITE;
            out_d.wr_n             = (state_d != StAPulse);
        end else if (is_data_state(state_d)) begin
            out_d.cs_n             = 1'b0;
            out_d.ad_n             = PHASE_DATA;
            out_d.flag_dato        = 1'b1;
            out_d.direccion_dato   = PHASE_DATA;
            out_d.controlador_dato = rw_d;
            out_d.bus_release      = (rw_d == DIR_READ);
            if (state_d == StDPulse) begin
                out_d.wr_n       = (rw_d != DIR_WRITE);
                out_d.rd_n       = (rw_d != DIR_READ);
                out_d.rd_capture = (rw_d == DIR_READ) && last_next;
            end
        end else if (state_d == StDone) begin
            out_d.done = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            rw_q    <= DIR_READ;
            out_q   <= BUS_OUT_IDLE;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            out_q   <= out_d;
        end
    end

    assign busy             = out_q.busy;
    assign done             = out_q.done;
    assign rd_capture       = out_q.rd_capture;
    assign cs_n             = out_q.cs_n;
    assign ad_n             = out_q.ad_n;
    assign wr_n             = out_q.wr_n;
    assign rd_n             = out_q.rd_n;
    assign flag_dato        = out_q.flag_dato;
    assign direccion_dato   = out_q.direccion_dato;
    assign controlador_dato = out_q.controlador_dato;
    assign bus_release      = out_q.bus_release;

    strobes_exclusive: assert property (@(posedge clk) disable iff (!reset) !(!wr_n && !rd_n));
    cs_implies_busy:   assert property (@(posedge clk) disable iff (!reset) !cs_n |-> busy);

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: scoreboard against a cycle-index model plus a table of
// hand-derived checkpoints; a second instance covers the minimum timing parameters.
module tb_rtc_bus_sequencer;

`ifdef RTC_RECOVERY_EN
    localparam int TREC = 4;
`else
    localparam int TREC = 0;
`endif

    // busy done rd_capture cs_n ad_n wr_n rd_n flag dir ctl rel
    typedef struct packed {
        logic busy;
        logic done;
        logic rd_capture;
        logic cs_n;
        logic ad_n;
        logic wr_n;
        logic rd_n;
        logic flag;
        logic dir;
        logic ctl;
        logic rel;
    } out_t;

    localparam out_t O_IDLE  = 11'b0_0_0_1_1_1_1_0_0_0_0;
    localparam out_t O_REC   = 11'b1_0_0_1_1_1_1_0_0_0_0;
    localparam out_t O_DONE  = 11'b1_1_0_1_1_1_1_0_0_0_0;
    localparam out_t O_ASET  = 11'b1_0_0_0_0_1_1_1_0_1_0;
    localparam out_t O_APUL  = 11'b1_0_0_0_0_0_1_1_0_1_0;
    localparam out_t O_DW    = 11'b1_0_0_0_1_1_1_1_1_1_0;
    localparam out_t O_DWPUL = 11'b1_0_0_0_1_0_1_1_1_1_0;
    localparam out_t O_DR    = 11'b1_0_0_0_1_1_1_1_1_0_1;
    localparam out_t O_DRPUL = 11'b1_0_0_0_1_1_0_1_1_0_1;
    localparam out_t O_DRCAP = 11'b1_0_1_0_1_1_0_1_1_0_1;

    typedef struct {
        int    d;
        logic  w;
        int    c;
        out_t  e;
        string nm;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start0 = 1'b0, rw0 = 1'b0, start1 = 1'b0, rw1 = 1'b0;
    logic busy0, done0, rdc0, csn0, adn0, wrn0, rdn0, flg0, dir0, ctl0, rel0;
    logic busy1, done1, rdc1, csn1, adn1, wrn1, rdn1, flg1, dir1, ctl1, rel1;
    out_t o0, o1;

    int   checks = 0;
    int   errors = 0;
    int   ts [2] = '{2, 1};
    int   tp [2] = '{4, 1};
    int   th [2] = '{2, 1};
    int   mc [2] = '{0, 0};
    logic mw [2] = '{1'b0, 1'b0};
    out_t sb [$];
    out_t tr [2][2][64];
    out_t bb [128];
    vec_t vt [$];

    always #5 clk = ~clk;

    rtc_bus_sequencer u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .rw(rw0),
        .busy(busy0), .done(done0), .rd_capture(rdc0), .cs_n(csn0), .ad_n(adn0),
        .wr_n(wrn0), .rd_n(rdn0), .flag_dato(flg0), .direccion_dato(dir0),
        .controlador_dato(ctl0), .bus_release(rel0)
    );

    rtc_bus_sequencer #(
        .T_SETUP(1), .T_PULSE(1), .T_HOLD(1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .rw(rw1),
        .busy(busy1), .done(done1), .rd_capture(rdc1), .cs_n(csn1), .ad_n(adn1),
        .wr_n(wrn1), .rd_n(rdn1), .flag_dato(flg1), .direccion_dato(dir1),
        .controlador_dato(ctl1), .bus_release(rel1)
    );

    assign o0 = {busy0, done0, rdc0, csn0, adn0, wrn0, rdn0, flg0, dir0, ctl0, rel0};
    assign o1 = {busy1, done1, rdc1, csn1, adn1, wrn1, rdn1, flg1, dir1, ctl1, rel1};

    function automatic int tot(input int d);
        return 2 * (ts[d] + tp[d] + th[d]) + 1 + TREC;
    endfunction

    // Expected outputs for cycle c (1 = first cycle after acceptance, 0 = idle).
    function automatic out_t expect_out(input int d, input logic w, input int c);
        out_t o;
        int   ae, de, p;
        logic data, pulse;
        o  = O_IDLE;
        ae = ts[d] + tp[d] + th[d];
        de = 2 * ae;
        if (c >= 1 && c <= de) begin
            data  = (c > ae);
            p     = data ? c - ae : c;
            pulse = (p > ts[d]) && (p <= ts[d] + tp[d]);
            o.busy = 1'b1;
            o.cs_n = 1'b0;
            o.ad_n = data;
            o.flag = 1'b1;
            o.dir  = data;
            o.ctl  = data ? w : 1'b1;
            o.rel  = data & ~w;
            o.wr_n = ~(pulse & (~data | w));
            o.rd_n = ~(pulse & data & ~w);
            o.rd_capture = data & ~w & (p == ts[d] + tp[d]);
        end else if (c == de + 1) begin
            o.busy = 1'b1;
            o.done = 1'b1;
        end else if (c > de + 1) begin
            o.busy = 1'b1;
        end
        return o;
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", name, act, exp);
        end
    endtask

    // Drive one cycle on instance d, advance the model, compare after the edge.
    task automatic tick(input int d, input logic s, input logic w, output out_t act);
        out_t exp;
        start0 = (d == 0) ? s : 1'b0;
        start1 = (d == 1) ? s : 1'b0;
        rw0    = w;
        rw1    = w;
        @(posedge clk);
        if (!reset) begin
            mc[d] = 0;
        end else if (mc[d] == 0) begin
            if (s) begin
                mc[d] = 1;
                mw[d] = w;
            end
        end else if (mc[d] == tot(d)) begin
            mc[d] = 0;
        end else begin
            mc[d]++;
        end
        sb.push_back(expect_out(d, mw[d], mc[d]));
        #1;
        act = (d == 0) ? o0 : o1;
        exp = sb.pop_front();
        check($sformatf("sb_d%0d_c%0d", d, mc[d]), act, exp);
        @(negedge clk);
    endtask

    task automatic run_txn(input int d, input logic w);
        out_t a;
        int   n;
        n = tot(d) + 3;
        tick(d, 1'b1, w, a);
        tr[d][w][1] = a;
        for (int j = 1; j < n; j++) begin
            tick(d, 1'b0, 1'($urandom), a);
            tr[d][w][j+1] = a;
        end
    endtask

    function automatic vec_t mk(input int d, input logic w, input int c, input out_t e,
                                input string nm);
        vec_t v;
        v.d  = d;
        v.w  = w;
        v.c  = c;
        v.e  = e;
        v.nm = nm;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        out_t a;
        int   sec;

        vt.push_back(mk(0, 1'b1, 1,  O_ASET,  "wr_a_setup"));
        vt.push_back(mk(0, 1'b1, 3,  O_APUL,  "wr_a_pulse_first"));
        vt.push_back(mk(0, 1'b1, 6,  O_APUL,  "wr_a_pulse_last"));
        vt.push_back(mk(0, 1'b1, 7,  O_ASET,  "wr_a_hold"));
        vt.push_back(mk(0, 1'b1, 10, O_DW,    "wr_d_setup"));
        vt.push_back(mk(0, 1'b1, 11, O_DWPUL, "wr_d_pulse_first"));
        vt.push_back(mk(0, 1'b1, 14, O_DWPUL, "wr_d_pulse_last"));
        vt.push_back(mk(0, 1'b1, 15, O_DW,    "wr_d_hold"));
        vt.push_back(mk(0, 1'b1, 17, O_DONE,  "wr_done"));
        vt.push_back(mk(0, 1'b1, 18, (TREC > 0) ? O_REC : O_IDLE, "wr_after_done"));
        vt.push_back(mk(0, 1'b0, 3,  O_APUL,  "rd_addr_pulse"));
        vt.push_back(mk(0, 1'b0, 10, O_DR,    "rd_d_setup"));
        vt.push_back(mk(0, 1'b0, 11, O_DRPUL, "rd_d_pulse_first"));
        vt.push_back(mk(0, 1'b0, 13, O_DRPUL, "rd_d_pulse_mid"));
        vt.push_back(mk(0, 1'b0, 14, O_DRCAP, "rd_capture_cycle"));
        vt.push_back(mk(0, 1'b0, 15, O_DR,    "rd_d_hold"));
        vt.push_back(mk(0, 1'b0, 17, O_DONE,  "rd_done"));
        vt.push_back(mk(1, 1'b1, 1,  O_ASET,  "min_wr_a_setup"));
        vt.push_back(mk(1, 1'b1, 2,  O_APUL,  "min_wr_a_pulse"));
        vt.push_back(mk(1, 1'b1, 3,  O_ASET,  "min_wr_a_hold"));
        vt.push_back(mk(1, 1'b1, 5,  O_DWPUL, "min_wr_d_pulse"));
        vt.push_back(mk(1, 1'b1, 6,  O_DW,    "min_wr_d_hold"));
        vt.push_back(mk(1, 1'b1, 7,  O_DONE,  "min_wr_done"));
        vt.push_back(mk(1, 1'b0, 5,  O_DRCAP, "min_rd_capture"));
`ifdef RTC_RECOVERY_EN
        vt.push_back(mk(0, 1'b1, 21, O_REC,   "wr_rec_last"));
        vt.push_back(mk(0, 1'b1, 22, O_IDLE,  "wr_idle_after_rec"));
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_state_d0", o0, O_IDLE);
        check("reset_state_d1", o1, O_IDLE);
        reset = 1'b1;
        @(negedge clk);

        // Traced transactions on both instances, then table checkpoints
        run_txn(0, 1'b1);
        run_txn(0, 1'b0);
        run_txn(1, 1'b1);
        run_txn(1, 1'b0);
        foreach (vt[i]) begin
            check(vt[i].nm, tr[vt[i].d][vt[i].w][vt[i].c], vt[i].e);
        end

        // Start pulses during the transaction and its final busy cycle are ignored
        tick(0, 1'b1, 1'b1, a);
        for (int j = 1; j < tot(0) + 4; j++) begin
            tick(0, (j == 5 || j == tot(0)), 1'($urandom), a);
        end

        // Back-to-back with start held high
        sec = tot(0) + 2;
        tick(0, 1'b1, 1'b1, a);
        bb[1] = a;
        for (int j = 1; j < 2 * sec + 2; j++) begin
            tick(0, 1'b1, 1'($urandom), a);
            bb[j+1] = a;
        end
        check("b2b_idle_gap", bb[sec-1], O_IDLE);
        check("b2b_second_setup", bb[sec], O_ASET);
        tick(0, 1'b0, 1'b0, a);
        for (int j = 0; j < tot(0) + 2; j++) begin
            tick(0, 1'b0, 1'b0, a);
        end

        // Asynchronous reset in the middle of the address pulse
        tick(0, 1'b1, 1'b1, a);
        for (int j = 1; j < 4; j++) begin
            tick(0, 1'b0, 1'b1, a);
        end
        check("pre_reset_a_pulse", a, O_APUL);
        #1 reset = 1'b0;
        #1 check("reset_async", o0, O_IDLE);
        tick(0, 1'b0, 1'b0, a);
        tick(0, 1'b0, 1'b0, a);
        reset = 1'b1;
        for (int j = 0; j < tot(0) + 2; j++) begin
            tick(0, 1'b0, 1'b0, a);
        end

        // Recovers cleanly after reset
        run_txn(0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
